// File: rtl/cordic_rot_seq.sv
// rtl/cordic_rot_seq.sv - iterative circular CORDIC rotation sequencer
// One micro-rotation per clock, angle supplied by an external atan(2^-i) ROM.
module cordic_rot_seq #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic        [3:0]       i,
    input  logic        [15:0]      alpha_i,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out
);

    localparam int EW = WIDTH + 2;
    localparam logic signed [EW-1:0] SAT_MAX = EW'((1 <<< (WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = -SAT_MAX;
    localparam logic [3:0] LAST_I = 4'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic [3:0] i_q, i_d;
    logic signed [EW-1:0] xr_q, xr_d, yr_q, yr_d, zr_q, zr_d;
    logic signed [EW-1:0] x_shift, y_shift, alpha_ext;
    logic signed [EW-1:0] x_step, y_step, z_step;
    logic signed [WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;

    // Symmetric clamp keeps the negative full-scale code out of the results.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [EW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[WIDTH-1:0];
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    always_comb begin
        x_shift   = xr_q >>> i_q;
        y_shift   = yr_q >>> i_q;
        alpha_ext = signed'(EW'(alpha_i));
        if (!zr_q[EW-1]) begin
            x_step = xr_q - y_shift;
            y_step = yr_q + x_shift;
            z_step = zr_q - alpha_ext;
        end else begin
            x_step = xr_q + y_shift;
            y_step = yr_q - x_shift;
            z_step = zr_q + alpha_ext;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        zr_d    = zr_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        z_out_d = z_out_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    i_d     = 4'd0;
                    xr_d    = {{2{x_in[WIDTH-1]}}, x_in};
                    yr_d    = {{2{y_in[WIDTH-1]}}, y_in};
                    zr_d    = {{2{z_in[WIDTH-1]}}, z_in};
                end
            end
            RUN: begin
                busy = 1'b1;
                xr_d = x_step;
                yr_d = y_step;
                zr_d = z_step;
                if (i_q == LAST_I) begin
                    state_d = DONE;
                    i_d     = 4'd0;
                    x_out_d = sat(x_step);
                    y_out_d = sat(y_step);
                    z_out_d = z_step[WIDTH-1:0];
                end else begin
                    i_d = i_q + 4'd1;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = RUN;
                    i_d     = 4'd0;
                    xr_d    = {{2{x_in[WIDTH-1]}}, x_in};
                    yr_d    = {{2{y_in[WIDTH-1]}}, y_in};
                    zr_d    = {{2{z_in[WIDTH-1]}}, z_in};
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= 4'd0;
            xr_q    <= '0;
            yr_q    <= '0;
            zr_q    <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            zr_q    <= zr_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            z_out_q <= z_out_d;
        end
    end

    assign i     = i_q;
    assign x_out = x_out_q;
    assign y_out = y_out_q;
    assign z_out = z_out_q;

endmodule
